spi_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one SPI monarch (`spi_mnrch`) between up to `NUM_REQ` independent requesters, e.g. inertial sensor and A2D polling. It accepts one 16-bit command per requester, issues it as a single `wrt` pulse, and detects completion on the rising edge of the monarch's sticky `done`. It returns the 16-bit read data to the granted requester with a one-cycle acknowledge.

---
 rtl/spi_arb_pkg.sv | 16 +
 rtl/spi_arb_if.sv | 34 +++
 rtl/spi_arb_rr_pick.sv | 30 +++
 rtl/spi_arb.sv | 130 +++++++++++++
 tb/tb_spi_arb.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI monarch arbiter.
// Holds the FSM state enum, the SPI word width and the timeout fill word.
package spi_arb_pkg;

  localparam int SPI_W = 16;

  localparam logic [SPI_W-1:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/spi_arb_if.sv
// spi_arb_if: requester bus plus SPI monarch link of the arbiter.
// slave = arbiter view, master = requesters/monarch view.
interface spi_arb_if
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SPI_W-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic [SPI_W-1:0]         rsp_data;
  logic                     err;
  logic                     busy;
  logic                     spi_wrt;
  logic [SPI_W-1:0]         spi_wt_data;
  logic                     spi_done;
  logic [SPI_W-1:0]         spi_rd_data;

  modport slave (
    input  req, req_data,
    input  spi_done, spi_rd_data,
    output ack, rsp_data, err, busy,
    output spi_wrt, spi_wt_data
  );

  modport master (
    output req, req_data,
    output spi_done, spi_rd_data,
    input  ack, rsp_data, err, busy,
    input  spi_wrt, spi_wt_data
  );

endinterface

// File: rtl/spi_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at rr_ptr.
// Ports: req, rr_ptr in; gnt_idx (first requester found), any out.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Walk from the farthest slot back to rr_ptr so the
  // nearest requester is the last (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % N);
      if (req[j]) begin
        gnt_idx = j;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// spi_arb: round-robin sharing of one SPI monarch by NUM_REQ requesters.
// Ports: clk, rst (async, high), bus (spi_arb_if.slave). Option: SPI_ARB_TIMEOUT_EN.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic     clk,
  input  logic     rst,
  spi_arb_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      nxt_ptr;
  logic               any;
  logic [SPI_W-1:0]   cmd_q;
  logic [SPI_W-1:0]   rsp_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               wrt_q;
  logic               done_q;
  logic               spi_ready;
  logic               cpl;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          tmo;
  assign tmo     = (cnt == CW'(TIMEOUT_CYC - 1));
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .gnt_idx (pick),
    .any     (any)
  );

  // A done level left over from the last frame is not a
  // completion; only a fresh rise counts.
  assign cpl = bus.spi_done & ~done_q;

  assign nxt_ptr = (gnt_idx == IW'(NUM_REQ - 1))
                 ? '0 : gnt_idx + IW'(1);

  assign bus.ack         = ack_q;
  assign bus.rsp_data    = rsp_q;
  assign bus.busy        = (state != IDLE);
  assign bus.spi_wrt     = wrt_q;
  assign bus.spi_wt_data = cmd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cmd_q     <= '0;
      rsp_q     <= '0;
      ack_q     <= '0;
      wrt_q     <= 1'b0;
      done_q    <= 1'b0;
      spi_ready <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q    <= bus.spi_done;
      // Monarch may still be mid-frame after a reset:
      // hold off until its done has been seen.
      spi_ready <= spi_ready | bus.spi_done;
      wrt_q     <= 1'b0;
      ack_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any && spi_ready) begin
            gnt_idx <= pick;
            cmd_q   <= bus.req_data[int'(pick)*SPI_W +: SPI_W];
            wrt_q   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (cpl) begin
            rsp_q <= bus.spi_rd_data;
            ack_q <= NUM_REQ'(1) << gnt_idx;
            state <= RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo) begin
            rsp_q     <= TIMEOUT_DATA;
            ack_q     <= NUM_REQ'(1) << gnt_idx;
            err_q     <= 1'b1;
            spi_ready <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed bench for spi_arb with a monarch model
// and a cycle-level reference model checked every cycle.
module tb_spi_arb;

  localparam int N  = 4;
  localparam int TO = 32;

  logic clk;
  logic rst;
  logic mon_done;
  logic done_block;

  spi_arb_if #(.NUM_REQ(N)) bus ();

  assign bus.spi_done = mon_done & ~done_block;

  spi_arb #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Monarch model: samples wt_data at wrt, clears done the cycle
  // after (or mon_lag cycles later), raises it after mon_frame.
  logic [15:0] mon_key;
  int          mon_frame;
  int          mon_lag;
  bit          mon_hang;
  int          n_wrt;
  logic [15:0] last_cmd;

  initial begin
    int  left;
    int  lag_left;
    bit  pend;
    mon_done        = 1'b1;
    bus.spi_rd_data = 16'h0BAD;
    n_wrt           = 0;
    last_cmd        = '0;
    left            = 0;
    lag_left        = 0;
    pend            = 0;
    forever begin
      @(negedge clk);
      if (left == -1) begin
        if (!mon_hang) begin
          left            = 0;
          mon_done        = 1'b1;
          bus.spi_rd_data = last_cmd ^ mon_key;
        end
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          mon_done        = 1'b1;
          bus.spi_rd_data = last_cmd ^ mon_key;
        end
      end
      if (bus.spi_wrt) begin
        n_wrt++;
        last_cmd = bus.spi_wt_data;
        pend     = 1;
        lag_left = mon_lag;
      end else if (pend) begin
        if (lag_left > 0) lag_left--;
        else begin
          pend     = 0;
          mon_done = 1'b0;
          left     = mon_hang ? -1 : mon_frame;
        end
      end
    end
  end

  // Reference model: a transfer record with edge stamps.
  int          edge_n = 0;
  bit          m_act;
  bit          m_ready;
  bit          m_dq;
  int          m_own;
  int          m_acc;
  int          m_cpl;
  int          m_ptr;
  logic [15:0] m_cmd;
  logic [15:0] m_rsp;
  logic [3:0]  m_ack;
  bit          m_wrt;
  bit          m_err;

  always @(posedge clk) begin
    bit to_hit;
    bit found;
    int j;
    edge_n++;
    to_hit = 0;
    if (rst) begin
      m_act = 0; m_ready = 0; m_dq = 0; m_ptr = 0;
      m_own = 0; m_acc = 0; m_cpl = -1;
      m_cmd = '0; m_rsp = '0; m_ack = '0;
      m_wrt = 0; m_err = 0;
    end else begin
      m_wrt = 0; m_ack = '0; m_err = 0;
      if (!m_act) begin
        if (m_ready && bus.req != '0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && bus.req[j]) begin
              found = 1;
              m_own = j;
            end
          end
          m_act = 1;
          m_acc = edge_n;
          m_cpl = -1;
          m_cmd = bus.req_data[m_own*16 +: 16];
          m_wrt = 1;
        end
      end else if (m_cpl >= 0) begin
        m_act = 0;
        m_ptr = (m_own + 1) % N;
      end else if (edge_n >= m_acc + 2) begin
        if (bus.spi_done && !m_dq) begin
          m_cpl = edge_n;
          m_ack = 4'(1 << m_own);
          m_rsp = bus.spi_rd_data;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (edge_n == m_acc + TO + 1) begin
          m_cpl  = edge_n;
          m_ack  = 4'(1 << m_own);
          m_rsp  = 16'hDEAD;
          m_err  = 1;
          to_hit = 1;
        end
`endif
      end
      m_ready = to_hit ? 1'b0 : (m_ready | bus.spi_done);
      m_dq    = bus.spi_done;
    end
    #1;
    chk("cyc_ack", 32'(bus.ack), 32'(m_ack));
    chk("cyc_rsp", 32'(bus.rsp_data), 32'(m_rsp));
    chk("cyc_err", 32'(bus.err), 32'(m_err));
    chk("cyc_busy", 32'(bus.busy), 32'(m_act));
    chk("cyc_wrt", 32'(bus.spi_wrt), 32'(m_wrt));
    chk("cyc_wt", 32'(bus.spi_wt_data), 32'(m_cmd));
  end

  task automatic wait_ack(input int max, output logic [3:0] a,
                          output logic [15:0] d, output logic e);
    a = '0; d = '0; e = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack; d = bus.rsp_data; e = bus.err;
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL ack_wait: no ack in %0d cycles", max);
  endtask

  task automatic wait_wrt(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.spi_wrt) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wrt_wait: no wrt in %0d cycles", max);
  endtask

  logic [3:0]  a;
  logic [15:0] d;
  logic        e;
  int          w0;
  int          cyc;
  int          seq [5] = '{0, 1, 2, 3, 0};
  logic [15:0] cmd;

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    done_block   = 1'b1;
    mon_key      = 16'hA55A ^ 16'h1234;
    mon_frame    = 4;
    mon_lag      = 0;
    mon_hang     = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_wrt", 32'(bus.spi_wrt), 0);
    chk("rst_wt", 32'(bus.spi_wt_data), 0);
    chk("rst_rsp", 32'(bus.rsp_data), 0);
    rst = 1'b0;

    // single request, gated until done is seen
    bus.req_data[31:16] = 16'hA55A;
    bus.req             = 4'b0010;
    repeat (4) @(negedge clk);
    chk("gate_nwrt", 32'(n_wrt), 0);
    done_block = 1'b0;
    wait_ack(40, a, d, e);
    chk("single_ack", 32'(a), 32'h2);
    chk("single_rsp", 32'(d), 32'h1234);
    chk("single_cmd", 32'(last_cmd), 32'hA55A);
    chk("single_nwrt", 32'(n_wrt), 1);
    @(negedge clk);
    bus.req = '0;

    // fairness from a fresh pointer
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    mon_key = 16'h0F0F;
    for (int i = 0; i < N; i++)
      bus.req_data[i*16 +: 16] = 16'(16'h1111 * (i + 1));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w0 = n_wrt;
      wait_ack(40, a, d, e);
      cmd = 16'(16'h1111 * (seq[k] + 1));
      chk("fair_ack", 32'(a), 32'(1 << seq[k]));
      chk("fair_1hot", 32'($onehot(a)), 1);
      chk("fair_rsp", 32'(d), 32'(cmd ^ 16'h0F0F));
      chk("fair_wrt", 32'(n_wrt - w0), 1);
    end
    @(negedge clk);
    bus.req = '0;

    // request drop and data change mid-transfer
    mon_frame           = 8;
    bus.req_data[47:32] = 16'h5A5A;
    bus.req             = 4'b0100;
    wait_wrt(20);
    @(negedge clk);
    bus.req             = '0;
    bus.req_data[47:32] = 16'hFFFF;
    wait_ack(40, a, d, e);
    chk("drop_ack", 32'(a), 32'h4);
    chk("drop_cmd", 32'(last_cmd), 32'h5A5A);
    chk("drop_rsp", 32'(d), 32'(16'h5A5A ^ 16'h0F0F));

    // reset in WAIT while the pointer sits at 3
    mon_frame           = 12;
    bus.req_data[31:16] = 16'h0123;
    bus.req             = 4'b0010;
    wait_wrt(20);
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_rsp", 32'(bus.rsp_data), 0);
    chk("mid_rst_wt", 32'(bus.spi_wt_data), 0);
    rst                 = 1'b0;
    w0                  = n_wrt;
    bus.req_data[63:48] = 16'h0F00;
    bus.req             = 4'b1010;
    for (int i = 0; i < 30 && !bus.spi_done; i++)
      @(negedge clk);
    chk("mid_gate", 32'(n_wrt - w0), 0);
    wait_ack(40, a, d, e);
    chk("mid_ack", 32'(a), 32'h2);
    chk("mid_rsp", 32'(d), 32'(16'h0123 ^ 16'h0F0F));
    @(negedge clk);
    bus.req = '0;

    // done stays high two cycles into WAIT
    mon_frame           = 4;
    mon_lag             = 2;
    bus.req_data[63:48] = 16'hC0DE;
    bus.req             = 4'b1000;
    wait_ack(40, a, d, e);
    chk("stale_ack", 32'(a), 32'h8);
    chk("stale_rsp", 32'(d), 32'(16'hC0DE ^ 16'h0F0F));
    @(negedge clk);
    bus.req = '0;
    mon_lag = 0;

`ifdef SPI_ARB_TIMEOUT_EN
    mon_hang            = 1;
    bus.req_data[15:0]  = 16'h7777;
    bus.req             = 4'b0001;
    wait_wrt(20);
    cyc = 0;
    a   = '0;
    for (int i = 0; i < 60 && a == '0; i++) begin
      @(negedge clk);
      cyc++;
      a = bus.ack; d = bus.rsp_data; e = bus.err;
    end
    chk("to_lat", 32'(cyc), 33);
    chk("to_ack", 32'(a), 32'h1);
    chk("to_err", 32'(e), 1);
    chk("to_rsp", 32'(d), 32'hDEAD);
    @(negedge clk);
    bus.req  = '0;
    mon_hang = 0;
    bus.req  = 4'b0011;
    wait_ack(60, a, d, e);
    chk("to_next", 32'(a), 32'h2);
    chk("to_next_err", 32'(e), 0);
    @(negedge clk);
    bus.req = '0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
